// File: rtl/servos_pkg.sv
// Shared state encoding and default timing for the servo sequencer.
package servos_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      GIRO    = 2'd1,
      RETORNO = 2'd2,
      FIM     = 2'd3
   } estado_t;

   // Default hold times in clock cycles (1 s each at 50 MHz)
   localparam int unsigned TEMPO_GIRO_PADRAO    = 32'd50_000_000;
   localparam int unsigned TEMPO_RETORNO_PADRAO = 32'd50_000_000;

endpackage : servos_pkg

// File: rtl/temporizador_servo.sv
// Up-counter for the sequencer phases; fim flags the last cycle of a phase.
module temporizador_servo #(
   parameter int unsigned W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         limpar,
   input  logic [W-1:0] limite,
   output logic         fim
);

   logic [W-1:0] contagem;

   // Count while running; hold at limite-1 so the count never wraps
   always_ff @(posedge clock) begin
      if (reset) begin
         contagem <= '0;
      end else if (limpar) begin
         contagem <= '0;
      end else if (!fim) begin
         contagem <= contagem + W'(1);
      end
   end

   assign fim = (contagem == (limite - W'(1)));

endmodule : temporizador_servo

// File: rtl/sequenciador_servos.sv
// Serialises one-bit position commands to a bank of PWM servo channels:
// one accepted command raises largura[sel] for TEMPO_GIRO cycles, then
// waits TEMPO_RETORNO cycles with all largura low, then pulses pronto.
module sequenciador_servos
   import servos_pkg::*;
#(
   parameter int unsigned NUM_SERVOS    = 4,
   parameter int unsigned SEL_W         = 3,
   parameter int unsigned TEMPO_GIRO    = TEMPO_GIRO_PADRAO,
   parameter int unsigned TEMPO_RETORNO = TEMPO_RETORNO_PADRAO
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  iniciar,
   input  logic [SEL_W-1:0]      servo_sel,
   input  logic                  abortar,
   output logic [NUM_SERVOS-1:0] largura,
   output logic                  ocupado,
   output logic                  pronto,
   output logic                  erro,
   output logic                  abortado
);

   localparam int unsigned TEMPO_MAX = (TEMPO_GIRO > TEMPO_RETORNO) ? TEMPO_GIRO : TEMPO_RETORNO;
   localparam int unsigned TW        = $clog2(TEMPO_MAX + 1);

   estado_t               estado, estado_prox;
   logic [SEL_W-1:0]      sel, sel_prox;
   logic [NUM_SERVOS-1:0] largura_prox;
   logic                  ocupado_prox, pronto_prox, erro_prox, abortado_prox;
   logic                  limpar, fim_tempo, sel_valido;
   logic [TW-1:0]         limite;

   assign sel_valido = (32'(servo_sel) < NUM_SERVOS);

   // Phase length depends on which phase is running
   assign limite = (estado == GIRO) ? TW'(TEMPO_GIRO) : TW'(TEMPO_RETORNO);

   temporizador_servo #(
      .W (TW)
   ) u_temporizador (
      .clock  (clock),
      .reset  (reset),
      .limpar (limpar),
      .limite (limite),
      .fim    (fim_tempo)
   );

   // Next state and next registered outputs
   always_comb begin
      estado_prox   = estado;
      sel_prox      = sel;
      largura_prox  = largura;
      ocupado_prox  = ocupado;
      pronto_prox   = 1'b0;
      erro_prox     = 1'b0;
      abortado_prox = abortado;
      limpar        = 1'b0;

      case (estado)
         OCIOSO: begin
            limpar = 1'b1;
            if (iniciar) begin
               if (sel_valido) begin
                  sel_prox      = servo_sel;
                  largura_prox  = '0;
                  for (int i = 0; i < int'(NUM_SERVOS); i++) begin
                     if (servo_sel == SEL_W'(i)) largura_prox[i] = 1'b1;
                  end
                  ocupado_prox  = 1'b1;
                  abortado_prox = 1'b0;
                  estado_prox   = GIRO;
               end else begin
                  erro_prox = 1'b1;
               end
            end
         end
         GIRO: begin
            // An abort shortens the turn but still waits the full return time
            if (abortar || fim_tempo) begin
               largura_prox = '0;
               limpar       = 1'b1;
               estado_prox  = RETORNO;
               if (abortar) abortado_prox = 1'b1;
            end
         end
         RETORNO: begin
            if (abortar) abortado_prox = 1'b1;
            if (fim_tempo) begin
               limpar      = 1'b1;
               pronto_prox = 1'b1;
               estado_prox = FIM;
            end
         end
         FIM: begin
            limpar       = 1'b1;
            ocupado_prox = 1'b0;
            estado_prox  = OCIOSO;
            if (abortar) abortado_prox = 1'b1;
         end
         default: begin
            limpar       = 1'b1;
            largura_prox = '0;
            ocupado_prox = 1'b0;
            estado_prox  = OCIOSO;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         estado   <= OCIOSO;
         sel      <= '0;
         largura  <= '0;
         ocupado  <= 1'b0;
         pronto   <= 1'b0;
         erro     <= 1'b0;
         abortado <= 1'b0;
      end else begin
         estado   <= estado_prox;
         sel      <= sel_prox;
         largura  <= largura_prox;
         ocupado  <= ocupado_prox;
         pronto   <= pronto_prox;
         erro     <= erro_prox;
         abortado <= abortado_prox;
      end
   end

endmodule : sequenciador_servos

// File: tb/tb_sequenciador_servos.sv
// Bench for sequenciador_servos: timeline model checked every cycle plus
// directed scenarios with hand-counted expectations.
module tb_sequenciador_servos;

   localparam int NS = 4;
   localparam int SW = 3;
   localparam int TG = 10;
   localparam int TR = 6;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          iniciar = 1'b0;
   logic [SW-1:0] servo_sel = '0;
   logic          abortar = 1'b0;
   logic [NS-1:0] largura;
   logic          ocupado, pronto, erro, abortado;

   int total = 0;
   int bad   = 0;

   sequenciador_servos #(
      .NUM_SERVOS    (NS),
      .SEL_W         (SW),
      .TEMPO_GIRO    (TG),
      .TEMPO_RETORNO (TR)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .iniciar   (iniciar),
      .servo_sel (servo_sel),
      .abortar   (abortar),
      .largura   (largura),
      .ocupado   (ocupado),
      .pronto    (pronto),
      .erro      (erro),
      .abortado  (abortado)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nome, input logic [31:0] real_v, input logic [31:0] esperado);
      total++;
      if (real_v !== esperado) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nome, real_v, esperado, $time);
      end
   endtask

   // Timeline model: a move is described by edges since acceptance (m_n)
   // and the edge index at which largura dropped (m_g).
   bit         modelo_ok = 0;
   bit         m_busy = 0;
   int         m_n = 0;
   int         m_g = TG;
   int         m_sel = 0;
   bit         m_abt = 0;
   bit         m_erro = 0;

   always @(posedge clock) begin
      if (reset) begin
         m_busy = 0; m_n = 0; m_g = TG; m_sel = 0; m_abt = 0; m_erro = 0;
         modelo_ok = 1;
      end else begin
         m_erro = 0;
         if (!m_busy) begin
            if (iniciar) begin
               if (int'(servo_sel) < NS) begin
                  m_busy = 1; m_n = 0; m_g = TG; m_sel = int'(servo_sel); m_abt = 0;
               end else begin
                  m_erro = 1;
               end
            end
         end else begin
            m_n++;
            if (abortar) begin
               if (m_n <= m_g) m_g = m_n;
               m_abt = 1;
            end
            if (m_n == m_g + TR + 1) m_busy = 0;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clock) begin
      if (modelo_ok) begin
         logic [NS-1:0] e_larg;
         e_larg = '0;
         if (m_busy && m_n < m_g) e_larg[m_sel] = 1'b1;
         chk("model largura", 32'(largura), 32'(e_larg));
         chk("model ocupado", 32'(ocupado), 32'(m_busy));
         chk("model pronto", 32'(pronto), 32'(m_busy && m_n == m_g + TR));
         chk("model erro", 32'(erro), 32'(m_erro));
         chk("model abortado", 32'(abortado), 32'(m_abt));
      end
   end

   // Command issued at a negedge, accepted at the following posedge
   task automatic aceitar(input int s);
      iniciar   = 1'b1;
      servo_sel = SW'(s);
      @(negedge clock);
      iniciar   = 1'b0;
   endtask

   task automatic ocioso(input int n);
      iniciar = 1'b0; abortar = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   // Observe ciclos cycles from the negedge after acceptance, optionally
   // injecting iniciar/abortar at given cycle indices.
   task automatic observar(input int ciclos, input logic [NS-1:0] mascara,
                           input int i_ini, input int s_ini, input int i_abt, input bit manter,
                           output int n_larg, output int n_outro, output int n_ocup,
                           output int n_pronto, output int p_idx, output int n_erro);
      n_larg = 0; n_outro = 0; n_ocup = 0; n_pronto = 0; p_idx = -1; n_erro = 0;
      for (int i = 0; i < ciclos; i++) begin
         if (largura == mascara) n_larg++;
         else if (largura != '0) n_outro++;
         if (ocupado) n_ocup++;
         if (pronto) begin
            n_pronto++;
            if (p_idx < 0) p_idx = i;
         end
         if (erro) n_erro++;
         iniciar = manter || (i == i_ini);
         if (i == i_ini) servo_sel = SW'(s_ini);
         abortar = (i == i_abt);
         @(negedge clock);
      end
      iniciar = 1'b0;
      abortar = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nl, no, nc, np, pi, ne;

      repeat (3) @(negedge clock);
      chk("reset largura", 32'(largura), 32'h0);
      chk("reset ocupado", 32'(ocupado), 32'h0);
      chk("reset abortado", 32'(abortado), 32'h0);
      reset = 1'b0;
      ocioso(2);

      // 1 normal move on servo 2
      aceitar(2);
      observar(20, 4'b0100, -1, 0, -1, 0, nl, no, nc, np, pi, ne);
      chk("t1 largura cycles", 32'(nl), 32'd10);
      chk("t1 stray largura", 32'(no), 32'd0);
      chk("t1 ocupado cycles", 32'(nc), 32'd17);
      chk("t1 pronto index", 32'(pi), 32'd16);
      chk("t1 pronto count", 32'(np), 32'd1);
      ocioso(2);

      // 2 invalid index
      aceitar(5);
      chk("t2 erro", 32'(erro), 32'd1);
      chk("t2 largura", 32'(largura), 32'd0);
      chk("t2 ocupado", 32'(ocupado), 32'd0);
      @(negedge clock);
      chk("t2 erro one cycle", 32'(erro), 32'd0);
      chk("t2 still idle", 32'(ocupado), 32'd0);
      ocioso(2);

      // 3 command while busy is ignored
      aceitar(0);
      observar(22, 4'b0001, 3, 1, -1, 0, nl, no, nc, np, pi, ne);
      chk("t3 largura cycles", 32'(nl), 32'd10);
      chk("t3 stray largura", 32'(no), 32'd0);
      chk("t3 pronto count", 32'(np), 32'd1);
      chk("t3 erro count", 32'(ne), 32'd0);
      ocioso(2);

      // 4 abort at GIRO cycle 4: drop at edge 5, pronto 6 cycles later
      aceitar(1);
      observar(16, 4'b0010, -1, 0, 4, 0, nl, no, nc, np, pi, ne);
      chk("t4 largura cycles", 32'(nl), 32'd5);
      chk("t4 pronto index", 32'(pi), 32'd11);
      chk("t4 ocupado cycles", 32'(nc), 32'd12);
      chk("t4 abortado sticky", 32'(abortado), 32'd1);
      ocioso(1);
      chk("t4 abortado held", 32'(abortado), 32'd1);
      aceitar(3);
      chk("t4 abortado cleared", 32'(abortado), 32'd0);
      ocioso(20);

      // 5 reset during RETORNO
      aceitar(3);
      ocioso(12);
      reset = 1'b1;
      @(negedge clock);
      chk("t5 largura", 32'(largura), 32'd0);
      chk("t5 ocupado", 32'(ocupado), 32'd0);
      chk("t5 pronto", 32'(pronto), 32'd0);
      reset = 1'b0;
      ocioso(1);
      aceitar(3);
      observar(20, 4'b1000, -1, 0, -1, 0, nl, no, nc, np, pi, ne);
      chk("t5 largura cycles", 32'(nl), 32'd10);
      chk("t5 pronto index", 32'(pi), 32'd16);
      chk("t5 ocupado cycles", 32'(nc), 32'd17);
      ocioso(2);

      // 6 iniciar held: a new move every 17 busy cycles + 1 idle cycle
      iniciar   = 1'b1;
      servo_sel = '0;
      @(negedge clock);
      observar(54, 4'b0001, -1, 0, -1, 1, nl, no, nc, np, pi, ne);
      chk("t6 largura cycles", 32'(nl), 32'd30);
      chk("t6 pronto count", 32'(np), 32'd3);
      chk("t6 first pronto", 32'(pi), 32'd16);
      chk("t6 ocupado cycles", 32'(nc), 32'd51);
      ocioso(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_sequenciador_servos
